// File: rtl/memory_request_tracker.sv
// Memory request tracker: one-entry request buffer, read/write serials, outstanding counts, busy.
// Define RSD_MEM_READ_RESP_REG_EN to register the read-return outputs (+1 cycle latency).
module memory_request_tracker #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 128,
    parameter int SERIAL_WIDTH = 4,
    parameter int READ_DEPTH   = 8,
    parameter int WRITE_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [ADDR_WIDTH-1:0]   memAccessAddr,
    input  logic [DATA_WIDTH-1:0]   memAccessWriteData,
    input  logic                    memAccessRE,
    input  logic                    memAccessWE,
    output logic [SERIAL_WIDTH-1:0] nextMemReadSerial,
    output logic [SERIAL_WIDTH-1:0] nextMemWriteSerial,
    output logic                    memAccessReadBusy,
    output logic                    memAccessWriteBusy,
    output logic [DATA_WIDTH-1:0]   memReadData,
    output logic                    memReadDataReady,
    output logic [SERIAL_WIDTH-1:0] memReadSerial,
    output logic [SERIAL_WIDTH:0]   memAccessResponse,
    output logic                    memReqValid,
    input  logic                    memReqReady,
    output logic                    memReqWE,
    output logic [ADDR_WIDTH-1:0]   memReqAddr,
    output logic [DATA_WIDTH-1:0]   memReqData,
    input  logic                    memRdValid,
    input  logic [DATA_WIDTH-1:0]   memRdData,
    input  logic                    memWrAckValid
);

    localparam int RCW = $clog2(READ_DEPTH) + 1;
    localparam int WCW = $clog2(WRITE_DEPTH) + 1;

    logic                    r_reqValid;
    logic                    r_reqWE;
    logic [ADDR_WIDTH-1:0]   r_reqAddr;
    logic [DATA_WIDTH-1:0]   r_reqData;
    logic [SERIAL_WIDTH-1:0] r_readReqSerial;
    logic [SERIAL_WIDTH-1:0] r_readRespSerial;
    logic [SERIAL_WIDTH-1:0] r_writeReqSerial;
    logic [SERIAL_WIDTH-1:0] r_writeRespSerial;
    logic [RCW-1:0]          r_readCount;
    logic [WCW-1:0]          r_writeCount;

    logic w_load;
    logic w_drain;
    logic w_stall;
    logic w_rdAccept;
    logic w_wrAccept;
    logic w_rdDec;
    logic w_wrDec;

    // A simultaneous RE/WE is taken as a write; the read is dropped.
    assign w_wrAccept = memAccessWE;
    assign w_rdAccept = memAccessRE && !memAccessWE;
    assign w_load     = w_rdAccept || w_wrAccept;
    assign w_drain    = r_reqValid && memReqReady;
    assign w_stall    = r_reqValid && !memReqReady;
    // Returns with nothing outstanding do not underflow the counts.
    assign w_rdDec    = memRdValid && (r_readCount != '0);
    assign w_wrDec    = memWrAckValid && (r_writeCount != '0);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_reqValid <= 1'b0;
            r_reqWE    <= 1'b0;
            r_reqAddr  <= '0;
            r_reqData  <= '0;
        end else if (w_load) begin
            r_reqValid <= 1'b1;
            r_reqWE    <= w_wrAccept;
            r_reqAddr  <= memAccessAddr;
            r_reqData  <= memAccessWriteData;
        end else if (w_drain) begin
            r_reqValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_readReqSerial  <= '0;
            r_readRespSerial <= '0;
            r_readCount      <= '0;
        end else begin
            if (w_rdAccept)
                r_readReqSerial <= r_readReqSerial + SERIAL_WIDTH'(1);
            if (memRdValid)
                r_readRespSerial <= r_readRespSerial + SERIAL_WIDTH'(1);
            if (w_rdAccept && !w_rdDec)
                r_readCount <= r_readCount + RCW'(1);
            else if (!w_rdAccept && w_rdDec)
                r_readCount <= r_readCount - RCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_writeReqSerial  <= '0;
            r_writeRespSerial <= '0;
            r_writeCount      <= '0;
        end else begin
            if (w_wrAccept)
                r_writeReqSerial <= r_writeReqSerial + SERIAL_WIDTH'(1);
            if (memWrAckValid)
                r_writeRespSerial <= r_writeRespSerial + SERIAL_WIDTH'(1);
            if (w_wrAccept && !w_wrDec)
                r_writeCount <= r_writeCount + WCW'(1);
            else if (!w_wrAccept && w_wrDec)
                r_writeCount <= r_writeCount - WCW'(1);
        end
    end

    assign memReqValid        = r_reqValid;
    assign memReqWE           = r_reqWE;
    assign memReqAddr         = r_reqAddr;
    assign memReqData         = r_reqData;
    assign nextMemReadSerial  = r_readReqSerial;
    assign nextMemWriteSerial = r_writeReqSerial;
    assign memAccessReadBusy  = w_stall || (r_readCount == RCW'(READ_DEPTH));
    assign memAccessWriteBusy = w_stall || (r_writeCount == WCW'(WRITE_DEPTH));
    assign memAccessResponse  = {memWrAckValid, r_writeRespSerial};

`ifdef RSD_MEM_READ_RESP_REG_EN
    logic                    r_rdValid;
    logic [DATA_WIDTH-1:0]   r_rdData;
    logic [SERIAL_WIDTH-1:0] r_rdSerial;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_rdValid  <= 1'b0;
            r_rdData   <= '0;
            r_rdSerial <= '0;
        end else begin
            r_rdValid  <= memRdValid;
            r_rdData   <= memRdData;
            r_rdSerial <= r_readRespSerial;
        end
    end

    assign memReadDataReady = r_rdValid;
    assign memReadData      = r_rdData;
    assign memReadSerial    = r_rdSerial;
`else
    assign memReadDataReady = memRdValid;
    assign memReadData      = memRdData;
    assign memReadSerial    = r_readRespSerial;
`endif

endmodule
